// File: rtl/div_result_fixup.sv
// rtl/div_result_fixup.sv - signed/zero/overflow fix-up and in-order completion buffer behind the radix-2 divider
// Optional DIV_FIXUP_STATS_EN adds saturating dbz_count/ovf_count pop counters.
module div_result_fixup #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               opn_valid,
  input  logic               sign,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               res_valid,
  input  logic [2*WIDTH-1:0] div_result,
  output logic               issue_ok,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow,
  output logic               err_spurious
`ifdef DIV_FIXUP_STATS_EN
  ,
  output logic [7:0]         dbz_count,
  output logic [7:0]         ovf_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, PENDING, DONE} entry_state_e;

  entry_state_e     ent_state [DEPTH];
  logic             ent_sign  [DEPTH];
  logic [WIDTH-1:0] ent_d     [DEPTH];
  logic [WIDTH-1:0] ent_v     [DEPTH];
  logic [WIDTH-1:0] ent_q     [DEPTH];
  logic [WIDTH-1:0] ent_r     [DEPTH];
  logic             ent_dbz   [DEPTH];
  logic             ent_ovf   [DEPTH];

  logic [PW-1:0]    wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hold_q, hold_r;
  logic             hold_dbz, hold_ovf;

  logic             push, pop, fill_ok;
  logic             fs;
  logic [WIDTH-1:0] fd, fv, mq, mr, fq, fr;
  logic             fdbz, fovf;

  assign issue_ok  = (count != FULL);
  assign out_valid = (ent_state[rd_ptr] == DONE);
  assign push      = opn_valid && issue_ok;
  assign pop       = out_valid && out_ready;
  assign fill_ok   = (ent_state[fill_ptr] == PENDING);

  assign quotient    = out_valid ? ent_q[rd_ptr]   : hold_q;
  assign remainder   = out_valid ? ent_r[rd_ptr]   : hold_r;
  assign div_by_zero = out_valid ? ent_dbz[rd_ptr] : hold_dbz;
  assign overflow    = out_valid ? ent_ovf[rd_ptr] : hold_ovf;

  // The core only returns magnitudes; signs are reapplied from the snooped operands.
  always_comb begin
    fs   = ent_sign[fill_ptr];
    fd   = ent_d[fill_ptr];
    fv   = ent_v[fill_ptr];
    mq   = div_result[WIDTH-1:0];
    mr   = div_result[2*WIDTH-1:WIDTH];
    fq   = mq;
    fr   = mr;
    fdbz = 1'b0;
    fovf = 1'b0;
    if (fv == '0) begin
      fq   = '1;
      fr   = fd;
      fdbz = 1'b1;
    end else if (fs && fd == MIN_VAL && fv == '1) begin
      fq   = fd;
      fr   = '0;
      fovf = 1'b1;
    end else begin
      if (fs && (fd[WIDTH-1] ^ fv[WIDTH-1])) fq = ~mq + ONE;
      if (fs && fd[WIDTH-1])                 fr = ~mr + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_spurious <= 1'b0;
      hold_q       <= '0;
      hold_r       <= '0;
      hold_dbz     <= 1'b0;
      hold_ovf     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i] <= EMPTY;
        ent_sign[i]  <= 1'b0;
        ent_d[i]     <= '0;
        ent_v[i]     <= '0;
        ent_q[i]     <= '0;
        ent_r[i]     <= '0;
        ent_dbz[i]   <= 1'b0;
        ent_ovf[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        ent_state[wr_ptr] <= PENDING;
        ent_sign[wr_ptr]  <= sign;
        ent_d[wr_ptr]     <= dividend;
        ent_v[wr_ptr]     <= divisor;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (res_valid) begin
        if (fill_ok) begin
          ent_state[fill_ptr] <= DONE;
          ent_q[fill_ptr]     <= fq;
          ent_r[fill_ptr]     <= fr;
          ent_dbz[fill_ptr]   <= fdbz;
          ent_ovf[fill_ptr]   <= fovf;
          fill_ptr            <= fill_ptr + PTR_ONE;
        end else begin
          err_spurious <= 1'b1;
        end
      end
      if (pop) begin
        ent_state[rd_ptr] <= EMPTY;
        rd_ptr            <= rd_ptr + PTR_ONE;
      end
      count <= count + CW'(push) - CW'(pop);
      // Keep a copy of the head so the data outputs hold once it is popped.
      if (out_valid) begin
        hold_q   <= ent_q[rd_ptr];
        hold_r   <= ent_r[rd_ptr];
        hold_dbz <= ent_dbz[rd_ptr];
        hold_ovf <= ent_ovf[rd_ptr];
      end
    end
  end

`ifdef DIV_FIXUP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_count <= '0;
      ovf_count <= '0;
    end else if (pop) begin
      if (ent_dbz[rd_ptr] && dbz_count != 8'hFF) dbz_count <= dbz_count + 8'd1;
      if (ent_ovf[rd_ptr] && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_fixup.sv
// tb/tb_div_result_fixup.sv - directed vectors plus a queue-based arithmetic model for div_result_fixup
module tb_div_result_fixup;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        opn_valid = 1'b0, sign = 1'b0, res_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  dividend = '0, divisor = '0;
  logic [15:0] div_result = '0;
  logic        issue_ok, out_valid, div_by_zero, overflow, err_spurious;
  logic [7:0]  quotient, remainder;
`ifdef DIV_FIXUP_STATS_EN
  logic [7:0]  dbz_count, ovf_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_result_fixup #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .opn_valid(opn_valid), .sign(sign),
    .dividend(dividend), .divisor(divisor), .res_valid(res_valid),
    .div_result(div_result), .issue_ok(issue_ok), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow), .err_spurious(err_spurious)
`ifdef DIV_FIXUP_STATS_EN
    , .dbz_count(dbz_count), .ovf_count(ovf_count)
`endif
  );

  typedef struct { logic s; logic [7:0] d; logic [7:0] v; } op_t;
  typedef struct { logic [7:0] q; logic [7:0] r; logic dbz; logic ovf; } res_t;

  op_t  m_pend[$];
  res_t m_done[$];
  res_t m_last;
  logic m_spur;
  int   m_dbz_cnt, m_ovf_cnt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected result from ordinary truncating integer division.
  function automatic res_t expect_of(input op_t op);
    res_t e;
    int a, b;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (op.v == 8'h00) begin
      e.q = 8'hFF; e.r = op.d; e.dbz = 1'b1;
    end else if (op.s && op.d == 8'h80 && op.v == 8'hFF) begin
      e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1;
    end else begin
      if (op.s) begin
        a = int'($signed(op.d));
        b = int'($signed(op.v));
      end else begin
        a = int'(op.d);
        b = int'(op.v);
      end
      e.q = 8'(a / b);
      e.r = 8'(a % b);
    end
    return e;
  endfunction

  // What a working divider core would return: {|r|, |q|}.
  function automatic logic [15:0] core_of(input op_t op);
    logic [7:0] ad, av;
    if (op.v == 8'h00) return 16'hFFFF;
    ad = (op.s && op.d[7]) ? 8'(-op.d) : op.d;
    av = (op.s && op.v[7]) ? 8'(-op.v) : op.v;
    return {8'(ad % av), 8'(ad / av)};
  endfunction

  function automatic logic m_issue_ok();
    return (m_pend.size() + m_done.size()) < 4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend.delete();
      m_done.delete();
      m_spur = 1'b0;
      m_dbz_cnt = 0;
      m_ovf_cnt = 0;
    end else begin
      logic ok;
      ok = m_issue_ok();
      if (out_ready && m_done.size() > 0) begin
        if (m_done[0].dbz && m_dbz_cnt < 255) m_dbz_cnt++;
        if (m_done[0].ovf && m_ovf_cnt < 255) m_ovf_cnt++;
        void'(m_done.pop_front());
      end
      if (res_valid) begin
        if (m_pend.size() > 0) m_done.push_back(expect_of(m_pend.pop_front()));
        else m_spur = 1'b1;
      end
      if (opn_valid && ok) m_pend.push_back('{s: sign, d: dividend, v: divisor});
    end
  end

  always @(negedge clk) begin
    if (rst) m_last = '{q: 8'h00, r: 8'h00, dbz: 1'b0, ovf: 1'b0};
    else if (m_done.size() > 0) m_last = m_done[0];
    chk("out_valid", 32'(out_valid), 32'(m_done.size() > 0));
    chk("issue_ok", 32'(issue_ok), 32'(m_issue_ok()));
    chk("err_spurious", 32'(err_spurious), 32'(m_spur));
    chk("quotient", 32'(quotient), 32'(m_last.q));
    chk("remainder", 32'(remainder), 32'(m_last.r));
    chk("div_by_zero", 32'(div_by_zero), 32'(m_last.dbz));
    chk("overflow", 32'(overflow), 32'(m_last.ovf));
`ifdef DIV_FIXUP_STATS_EN
    chk("dbz_count", 32'(dbz_count), 32'(m_dbz_cnt));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf_cnt));
`endif
  end

  task automatic step(input logic ov, input logic s, input logic [7:0] d, input logic [7:0] v,
                      input logic rv, input logic [15:0] res);
    opn_valid = ov; sign = s; dividend = d; divisor = v;
    res_valid = rv; div_result = res;
    @(posedge clk); #1;
    opn_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    op_t op;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("lit reset issue_ok", 32'(issue_ok), 32'd1);
    chk("lit reset out_valid", 32'(out_valid), 32'd0);

    // Unsigned 100/7
    step(1'b1, 1'b0, 8'h64, 8'h07, 1'b0, 16'h0);
    chk("lit latency before fill", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h020E);
    chk("lit u100/7 valid", 32'(out_valid), 32'd1);
    chk("lit u100/7 q", 32'(quotient), 32'h0E);
    chk("lit u100/7 r", 32'(remainder), 32'h02);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("lit u100/7 hold q", 32'(quotient), 32'h0E);

    // Signed -100/7
    step(1'b1, 1'b1, 8'h9C, 8'h07, 1'b0, 16'h0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h020E);
    chk("lit s-100/7 q", 32'(quotient), 32'hF2);
    chk("lit s-100/7 r", 32'(remainder), 32'hFE);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // Divide by zero
    step(1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, 16'h0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'hFFFF);
    chk("lit dbz q", 32'(quotient), 32'hFF);
    chk("lit dbz r", 32'(remainder), 32'h2A);
    chk("lit dbz flag", 32'(div_by_zero), 32'd1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
`ifdef DIV_FIXUP_STATS_EN
    chk("lit dbz_count", 32'(dbz_count), 32'd1);
`endif

    // Signed overflow
    step(1'b1, 1'b1, 8'h80, 8'hFF, 1'b0, 16'h0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h0080);
    chk("lit ovf q", 32'(quotient), 32'h80);
    chk("lit ovf r", 32'(remainder), 32'h00);
    chk("lit ovf flag", 32'(overflow), 32'd1);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // Backpressure: fill all four entries, fifth issue ignored
    for (int i = 0; i < 4; i++) begin
      op = '{s: 1'b0, d: 8'(20 * i + 13), v: 8'd3};
      step(1'b1, op.s, op.d, op.v, 1'b0, 16'h0);
    end
    for (int i = 0; i < 4; i++) begin
      op = '{s: 1'b0, d: 8'(20 * i + 13), v: 8'd3};
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, core_of(op));
    end
    chk("lit full issue_ok", 32'(issue_ok), 32'd0);
    step(1'b1, 1'b0, 8'hEE, 8'h05, 1'b0, 16'h0);
    chk("lit full head q", 32'(quotient), 32'd4);
    out_ready = 1'b1;
    chk("lit issue_ok before pop", 32'(issue_ok), 32'd0);
    idle(1);
    chk("lit issue_ok after pop", 32'(issue_ok), 32'd1);
    chk("lit second head q", 32'(quotient), 32'd11);
    idle(3);
    chk("lit drained", 32'(out_valid), 32'd0);

    // Mixed traffic: concurrent push/fill/pop with toggling out_ready
    for (int i = 0; i < 60; i++) begin
      logic do_iss, do_fill;
      op_t nop;
      out_ready = ($urandom_range(0, 3) != 0);
      nop.s = 1'(i % 2);
      nop.d = 8'($urandom_range(0, 255));
      nop.v = (i % 11 == 5) ? 8'h00 : (i % 13 == 7) ? 8'hFF : 8'($urandom_range(1, 255));
      if (i % 17 == 3) begin nop.s = 1'b1; nop.d = 8'h80; nop.v = 8'hFF; end
      do_iss  = m_issue_ok() && ($urandom_range(0, 2) != 0);
      do_fill = (m_pend.size() > 0) && ($urandom_range(0, 1) != 0);
      step(do_iss, nop.s, nop.d, nop.v, do_fill, do_fill ? core_of(m_pend[0]) : 16'h0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b0, 8'h00, 8'h00, (m_pend.size() > 0),
           (m_pend.size() > 0) ? core_of(m_pend[0]) : 16'h0);

    // Reset mid-operation discards entries
    out_ready = 1'b0;
    step(1'b1, 1'b0, 8'h10, 8'h02, 1'b0, 16'h0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h0008);
    do_reset();
    chk("lit midreset out_valid", 32'(out_valid), 32'd0);
    chk("lit midreset q", 32'(quotient), 32'd0);

    // Spurious completion on an empty buffer
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h1234);
    chk("lit spurious set", 32'(err_spurious), 32'd1);
    chk("lit spurious out_valid", 32'(out_valid), 32'd0);
    idle(3);
    chk("lit spurious sticky", 32'(err_spurious), 32'd1);
    do_reset();
    chk("lit spurious cleared", 32'(err_spurious), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
